alarm_key_pio_in: RTL

//  Avalon-MM slave input PIO: the read-side counterpart of the SET/output PIOs in the alarm clock system.

---
 rtl/alarm_pio_pkg.sv | 13 +
 rtl/alarm_pio_debouncer.sv | 44 ++++
 rtl/alarm_key_pio_in.sv | 113 +++++++++++
 3 files changed

// File: rtl/alarm_pio_pkg.sv
// Shared register offsets and edge-mode encodings for the alarm clock PIO blocks.
package alarm_pio_pkg;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_RSVD = 2'd1;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/alarm_pio_debouncer.sv
// Single-bit debouncer: a new synchronized level must persist for DEBOUNCE_CYCLES
// consecutive cycles before it replaces the stable output.
module alarm_pio_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    // Any return to the stable level restarts the count, so short glitches are dropped.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (din == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = din;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/alarm_key_pio_in.sv
// Avalon-MM input PIO for the alarm clock keys: synchronize, debounce, capture
// edges into sticky RW1C flags and raise a maskable level interrupt.
module alarm_key_pio_in
    import alarm_pio_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] rise, fall, edge_det;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync_q  <= sync1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        alarm_pio_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (sync_q[i]),
            .dout   (stable[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_dly_q <= '0;
        end else begin
            stable_dly_q <= stable;
        end
    end

    assign rise = stable & ~stable_dly_q;
    assign fall = ~stable & stable_dly_q;

    always_comb begin
        edge_det = rise | fall;
        if (EDGE_TYPE == EDGE_RISE) edge_det = rise;
        else if (EDGE_TYPE == EDGE_FALL) edge_det = fall;
    end

    // Bus: a write is taken on any clk edge where chipselect=1 and write_n=0;
    // readdata is registered from address every edge, so it is valid one cycle later.
    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Set wins over RW1C clear so an edge arriving with the clear is never lost.
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q | edge_det;
        if (wr_en && address == PIO_MASK) begin
            mask_d = wdata;
        end
        if (wr_en && address == PIO_EDGE) begin
            edge_d = (edge_q & ~wdata) | edge_det;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_DATA: readdata_d[WIDTH-1:0] = stable;
            PIO_MASK: readdata_d[WIDTH-1:0] = mask_q;
            PIO_EDGE: readdata_d[WIDTH-1:0] = edge_q;
            default:  readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule
